writeback_queue: RTL and testbench
==================================

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, entries per lane queue (power of two, at least 2).
REQ-002 SHALL have parameter DATA_W, default 16, writeback value width.
REQ-003 SHALL have parameter ADDR_W, default 5, register address width.
REQ-004 SHALL have port clock_i  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_i  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port flush_i  in  1  pipeline flush, synchronous.
REQ-007 SHALL have ports resA_valid_i / resB_valid_i  in  1  exec result valid, per lane.
REQ-008 SHALL have ports resA_ready_o / resB_ready_o  out  1  lane can accept a result.
REQ-009 SHALL have ports resA_wb_i / resB_wb_i  in  1  result requires register writeback.
REQ-010 SHALL have ports resA_addr_i / resB_addr_i  in  ADDR_W  destination register.
REQ-011 SHALL have ports resA_data_i / resB_data_i  in  DATA_W  result value.
REQ-012 SHALL have ports resA_status_i / resB_status_i  in  2  operation status.
REQ-013 SHALL have ports wbStallA_i / wbStallB_i  in  1  register file cannot take a writeback this cycle.
REQ-014 SHALL have ports wbA_o / wbB_o  out  1  writeback enable, one-cycle pulse per entry.
REQ-015 SHALL have ports wbAddrA_o / wbAddrB_o  out  ADDR_W, wbValA_o / wbValB_o  out  DATA_W, operationStatusA_o / operationStatusB_o  out  2  writeback payload.
REQ-016 SHALL have ports countA_o / countB_o  out  clog2(DEPTH)+1  current occupancy.

Function
REQ-017 Result SHALL be accepted on a rising edge when valid and ready are both high.
REQ-018 Ready SHALL be high when count < DEPTH and flush_i is low; a push is not allowed to pass through a full queue even when a pop happens in the same cycle.
REQ-019 An accepted result with wb low SHALL be discarded: no entry is written and count is unchanged.
REQ-020 When the queue is non-empty and wbStall is low, the head SHALL be popped and presented on the registered outputs with wb high for exactly one cycle.
REQ-021 Latency from acceptance into an empty, unstalled queue to the wb pulse SHALL be 1 cycle; queue order SHALL be FIFO.
REQ-022 When wbStall is high, no pop SHALL occur, wb SHALL be low, and the head entry SHALL be retained.
REQ-023 A simultaneous push and pop on a non-full queue SHALL leave count unchanged.
REQ-024 Head and tail pointers SHALL wrap modulo DEPTH.
REQ-025 Lane A holds the older instruction: if both lanes pop in the same cycle with equal addresses, wbA_o SHALL be suppressed (entry still popped) and wbB_o asserted.
REQ-026 When flush_i is high, both queues SHALL be emptied at the next edge, wb outputs SHALL be low at that edge, and inputs in that cycle SHALL be dropped.

Reset
REQ-027 Asserting reset_i low SHALL immediately clear both counts and pointers and drive wb*_o low and wbAddr*_o, wbVal*_o and operationStatus*_o to 0.
REQ-028 Reset asserted mid-operation SHALL discard all queued entries; ready SHALL rise on the first edge after release.

Configuration
REQ-029 With macro WB_BYPASS_EN defined, a result arriving at an empty, unstalled lane SHALL drive the wb outputs combinationally in the same cycle without being enqueued, and REQ-025 SHALL also apply to bypassed results.
REQ-030 Without WB_BYPASS_EN, all outputs SHALL be registered and REQ-021 latency applies.

Structure
REQ-031 Shared package wb_pkg SHALL hold ADDR_W, DATA_W, the 2-bit status encodings and the entry typedef {addr, data, status}.
REQ-032 Each lane SHALL instantiate one sub-module wb_fifo (DEPTH entries, push/pop/count), so there are two instances.

Verification
REQ-033 Push A addr=3 data=0x1234 into an empty queue with no stall -> wbA_o pulses 1 cycle later, with wbAddrA_o=3 and wbValA_o=0x1234.
REQ-034 Hold wbStallA_i high and push 4 results -> resA_ready_o goes low and countA_o=4; release the stall -> 4 pulses in order on consecutive cycles.
REQ-035 Both lanes pop addr=7 in the same cycle (A=0x1, B=0x2) -> only wbB_o asserts, with wbValB_o=0x2.
REQ-036 Fill A with 3 entries, then assert flush_i -> countA_o=0 next cycle, no wbA_o pulse, and the flush-cycle input is dropped.
REQ-037 Push with resA_wb_i=0 -> no pulse and countA_o unchanged; assert reset_i low mid-queue -> outputs are 0 immediately.
REQ-038 With WB_BYPASS_EN defined, a push into an empty lane -> wbA_o high in the same cycle.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the two-lane writeback queue: default widths,
// operation status encodings and the queued entry layout.
package wb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    WB_ST_OK    = 2'b00,
    WB_ST_EXC   = 2'b01,
    WB_ST_TRAP  = 2'b10,
    WB_ST_ABORT = 2'b11
  } wb_status_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [1:0]        status;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Per-lane circular FIFO with head/tail pointers wrapping modulo DEPTH.
// Pushes into a full queue are ignored; flush empties it on the next edge.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 23
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           wdata_i,
  output logic [W-1:0]           head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  import wb_pkg::*;

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [PW:0]   count_q;
  logic          do_push_s;
  logic          do_pop_s;

  assign full_o    = (count_q == (PW+1)'(DEPTH));
  assign empty_o   = (count_q == {(PW+1){1'b0}});
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;
  assign head_o    = mem_q[head_q];
  assign count_o   = count_q;

  // pointer and occupancy state; power-of-two depth makes wrap implicit
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push_s) tail_q <= tail_q + 1'b1;
      if (do_pop_s)  head_q <= head_q + 1'b1;
      count_q <= count_q + (PW+1)'(do_push_s) - (PW+1)'(do_pop_s);
    end
  end

  // entry storage; never read while empty, so it carries no reset
  always_ff @(posedge clock_i) begin
    if (do_push_s && !flush_i) mem_q[tail_q] <= wdata_i;
  end

endmodule

// File: rtl/writeback_queue.sv
// Two-lane writeback queue: lane A holds the older instruction of a pair.
// Optional macro WB_BYPASS_EN lets results skip an empty, idle lane combinationally.
module writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic                     resA_valid_i,
  input  logic                     resB_valid_i,
  output logic                     resA_ready_o,
  output logic                     resB_ready_o,
  input  logic                     resA_wb_i,
  input  logic                     resB_wb_i,
  input  logic [ADDR_W-1:0]        resA_addr_i,
  input  logic [ADDR_W-1:0]        resB_addr_i,
  input  logic [DATA_W-1:0]        resA_data_i,
  input  logic [DATA_W-1:0]        resB_data_i,
  input  logic [1:0]               resA_status_i,
  input  logic [1:0]               resB_status_i,
  input  logic                     wbStallA_i,
  input  logic                     wbStallB_i,
  output logic                     wbA_o,
  output logic                     wbB_o,
  output logic [ADDR_W-1:0]        wbAddrA_o,
  output logic [ADDR_W-1:0]        wbAddrB_o,
  output logic [DATA_W-1:0]        wbValA_o,
  output logic [DATA_W-1:0]        wbValB_o,
  output logic [1:0]               operationStatusA_o,
  output logic [1:0]               operationStatusB_o,
  output logic [$clog2(DEPTH):0]   countA_o,
  output logic [$clog2(DEPTH):0]   countB_o
);
  import wb_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [1:0]        status;
  } entry_t;

  localparam int EW = $bits(entry_t);

  logic [1:0]    valid_s, wbreq_s, stall_s, ready_s, accept_s;
  logic [1:0]    push_s, pop_s, byp_s, full_s, empty_s;
  logic [1:0]    wb_d, wb_q, sel_vld_s;
  logic          supp_s;
  logic          alive_q;
  entry_t        in_s    [2];
  entry_t        head_s  [2];
  entry_t        out_q   [2];
  entry_t        sel_e_s [2];
  logic [CW-1:0] count_s [2];

  assign valid_s  = {resB_valid_i, resA_valid_i};
  assign wbreq_s  = {resB_wb_i, resA_wb_i};
  assign stall_s  = {wbStallB_i, wbStallA_i};
  assign in_s[0]  = {resA_addr_i, resA_data_i, resA_status_i};
  assign in_s[1]  = {resB_addr_i, resB_data_i, resB_status_i};

  for (genvar g = 0; g < 2; g++) begin : g_lane
    wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .flush_i (flush_i),
      .push_i  (push_s[g]),
      .pop_i   (pop_s[g]),
      .wdata_i (in_s[g]),
      .head_o  (head_s[g]),
      .count_o (count_s[g]),
      .full_o  (full_s[g]),
      .empty_o (empty_s[g])
    );
  end

  // handshake, push/pop decisions and same-address collapse of the older lane
  always_comb begin
    ready_s  = 2'b00;
    accept_s = 2'b00;
    push_s   = 2'b00;
    pop_s    = 2'b00;
    byp_s    = 2'b00;
    for (int i = 0; i < 2; i++) begin
      ready_s[i]  = alive_q && !full_s[i] && !flush_i;
      accept_s[i] = valid_s[i] && ready_s[i];
      pop_s[i]    = !empty_s[i] && !stall_s[i] && !flush_i;
`ifdef WB_BYPASS_EN
      // the port must also be free of last cycle's registered pulse
      byp_s[i]    = accept_s[i] && wbreq_s[i] && empty_s[i] && !stall_s[i] && !wb_q[i];
`else
      byp_s[i]    = 1'b0;
`endif
      push_s[i]   = accept_s[i] && wbreq_s[i] && !byp_s[i];
    end
    supp_s  = pop_s[0] && pop_s[1] && (head_s[0].addr == head_s[1].addr);
    wb_d[0] = pop_s[0] && !supp_s;
    wb_d[1] = pop_s[1];
  end

  // registered writeback stage; payload holds between pulses
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      alive_q <= 1'b0;
      wb_q    <= 2'b00;
      for (int i = 0; i < 2; i++) out_q[i] <= '0;
    end else begin
      alive_q <= 1'b1;
      wb_q    <= flush_i ? 2'b00 : wb_d;
      for (int i = 0; i < 2; i++) begin
        if (pop_s[i]) out_q[i] <= head_s[i];
        else          out_q[i] <= out_q[i];
      end
    end
  end

  // output select: queued entries, or a bypassed result when enabled
  always_comb begin
    sel_vld_s = wb_q;
    sel_e_s   = out_q;
    for (int i = 0; i < 2; i++) begin
      if (byp_s[i]) begin
        sel_vld_s[i] = 1'b1;
        sel_e_s[i]   = in_s[i];
      end else begin
        sel_vld_s[i] = wb_q[i];
        sel_e_s[i]   = out_q[i];
      end
    end
  end

`ifdef WB_BYPASS_EN
  assign wbA_o = sel_vld_s[0] && !(sel_vld_s[1] && (sel_e_s[0].addr == sel_e_s[1].addr));
`else
  assign wbA_o = sel_vld_s[0];
`endif
  assign wbB_o              = sel_vld_s[1];
  assign wbAddrA_o          = sel_e_s[0].addr;
  assign wbAddrB_o          = sel_e_s[1].addr;
  assign wbValA_o           = sel_e_s[0].data;
  assign wbValB_o           = sel_e_s[1].data;
  assign operationStatusA_o = sel_e_s[0].status;
  assign operationStatusB_o = sel_e_s[1].status;
  assign countA_o           = count_s[0];
  assign countB_o           = count_s[1];
  assign resA_ready_o       = ready_s[0];
  assign resB_ready_o       = ready_s[1];

endmodule

// File: tb/tb_writeback_queue.sv
// Directed self-checking bench for writeback_queue (DEPTH=4, DATA_W=16, ADDR_W=5).
module tb_writeback_queue;

  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic        va, vb, ra, rb, wba_in, wbb_in, sta, stb;
  logic [4:0]  aa, ab;
  logic [15:0] da, db;
  logic [1:0]  sa, sb;
  logic        wbA, wbB;
  logic [4:0]  oaA, oaB;
  logic [15:0] ovA, ovB;
  logic [1:0]  osA, osB;
  logic [2:0]  cA, cB;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  writeback_queue #(.DEPTH(4), .DATA_W(16), .ADDR_W(5)) dut (
    .clock_i(clk), .reset_i(rst_n), .flush_i(flush),
    .resA_valid_i(va), .resB_valid_i(vb), .resA_ready_o(ra), .resB_ready_o(rb),
    .resA_wb_i(wba_in), .resB_wb_i(wbb_in), .resA_addr_i(aa), .resB_addr_i(ab),
    .resA_data_i(da), .resB_data_i(db), .resA_status_i(sa), .resB_status_i(sb),
    .wbStallA_i(sta), .wbStallB_i(stb), .wbA_o(wbA), .wbB_o(wbB),
    .wbAddrA_o(oaA), .wbAddrB_o(oaB), .wbValA_o(ovA), .wbValB_o(ovB),
    .operationStatusA_o(osA), .operationStatusB_o(osB),
    .countA_o(cA), .countB_o(cB)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic w, input logic [4:0] a, input logic [15:0] d, input logic [1:0] s);
    va = v; wba_in = w; aa = a; da = d; sa = s;
  endtask

  task automatic drive_b(input logic v, input logic w, input logic [4:0] a, input logic [15:0] d, input logic [1:0] s);
    vb = v; wbb_in = w; ab = a; db = d; sb = s;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; sta = 1'b0; stb = 1'b0;
    drive_a(1'b0, 1'b0, 5'd0, 16'h0000, 2'd0);
    drive_b(1'b0, 1'b0, 5'd0, 16'h0000, 2'd0);
    #2;
    tick(); tick();
    checks++; if (cA !== 3'd0 || cB !== 3'd0) begin errors++; $display("FAIL reset_count got %0d/%0d want 0/0", cA, cB); end
    checks++; if (wbA !== 1'b0 || oaA !== 5'd0 || ovA !== 16'h0000) begin errors++; $display("FAIL reset_out got wb=%b a=%0d v=%h want 0/0/0", wbA, oaA, ovA); end
    checks++; if (ra !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ra); end
    rst_n = 1'b1;
    #1;
    checks++; if (ra !== 1'b0) begin errors++; $display("FAIL ready_before_edge got %b want 0", ra); end
    tick();
    checks++; if (ra !== 1'b1 || rb !== 1'b1) begin errors++; $display("FAIL ready_after_edge got %b%b want 11", ra, rb); end
  endtask

  task automatic test_single();
    drive_a(1'b1, 1'b1, 5'd3, 16'h1234, 2'd1);
    tick();
    drive_a(1'b0, 1'b0, 5'd0, 16'h0000, 2'd0);
    checks++; if (wbA !== 1'b0 || cA !== 3'd1) begin errors++; $display("FAIL single_accept got wb=%b cnt=%0d want 0/1", wbA, cA); end
    tick();
    checks++; if (wbA !== 1'b1 || oaA !== 5'd3 || ovA !== 16'h1234 || osA !== 2'd1) begin errors++; $display("FAIL single_pulse got wb=%b a=%0d v=%h s=%0d want 1/3/1234/1", wbA, oaA, ovA, osA); end
    checks++; if (cA !== 3'd0) begin errors++; $display("FAIL single_count got %0d want 0", cA); end
    tick();
    checks++; if (wbA !== 1'b0) begin errors++; $display("FAIL single_one_cycle got %b want 0", wbA); end
  endtask

  task automatic test_stall_fill();
    sta = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 1'b1, 5'(10 + i), 16'hA000 + 16'(i), 2'd0);
      tick();
    end
    checks++; if (cA !== 3'd4 || ra !== 1'b0 || wbA !== 1'b0) begin errors++; $display("FAIL stall_full got cnt=%0d rdy=%b wb=%b want 4/0/0", cA, ra, wbA); end
    drive_a(1'b1, 1'b1, 5'd14, 16'hBEEF, 2'd0);
    tick();
    checks++; if (cA !== 3'd4) begin errors++; $display("FAIL full_push_blocked got %0d want 4", cA); end
    drive_a(1'b0, 1'b0, 5'd0, 16'h0000, 2'd0);
    sta = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (wbA !== 1'b1 || oaA !== 5'(10 + i) || ovA !== 16'hA000 + 16'(i)) begin errors++; $display("FAIL drain_%0d got wb=%b a=%0d v=%h want 1/%0d/%h", i, wbA, oaA, ovA, 10 + i, 16'hA000 + 16'(i)); end
    end
    tick();
    checks++; if (wbA !== 1'b0 || cA !== 3'd0) begin errors++; $display("FAIL drain_end got wb=%b cnt=%0d want 0/0", wbA, cA); end
  endtask

  task automatic test_push_pop();
    drive_a(1'b1, 1'b1, 5'd1, 16'h0111, 2'd0);
    tick();
    drive_a(1'b1, 1'b1, 5'd2, 16'h0222, 2'd2);
    tick();
    drive_a(1'b0, 1'b0, 5'd0, 16'h0000, 2'd0);
    checks++; if (cA !== 3'd1 || wbA !== 1'b1 || ovA !== 16'h0111) begin errors++; $display("FAIL push_pop_same got cnt=%0d wb=%b v=%h want 1/1/0111", cA, wbA, ovA); end
    tick();
    checks++; if (cA !== 3'd0 || wbA !== 1'b1 || ovA !== 16'h0222 || osA !== 2'd2) begin errors++; $display("FAIL push_pop_next got cnt=%0d wb=%b v=%h s=%0d want 0/1/0222/2", cA, wbA, ovA, osA); end
    tick();
  endtask

  task automatic test_same_addr();
    sta = 1'b1; stb = 1'b1;
    drive_a(1'b1, 1'b1, 5'd7, 16'h0001, 2'd0);
    drive_b(1'b1, 1'b1, 5'd7, 16'h0002, 2'd0);
    tick();
    drive_a(1'b1, 1'b1, 5'd4, 16'h0044, 2'd0);
    drive_b(1'b1, 1'b1, 5'd5, 16'h0055, 2'd0);
    tick();
    drive_a(1'b0, 1'b0, 5'd0, 16'h0000, 2'd0);
    drive_b(1'b0, 1'b0, 5'd0, 16'h0000, 2'd0);
    sta = 1'b0; stb = 1'b0;
    tick();
    checks++; if (wbA !== 1'b0 || wbB !== 1'b1 || ovB !== 16'h0002 || oaB !== 5'd7) begin errors++; $display("FAIL same_addr got wbA=%b wbB=%b vB=%h want 0/1/0002", wbA, wbB, ovB); end
    checks++; if (cA !== 3'd1 || cB !== 3'd1) begin errors++; $display("FAIL same_addr_pop got %0d/%0d want 1/1", cA, cB); end
    tick();
    checks++; if (wbA !== 1'b1 || wbB !== 1'b1 || ovA !== 16'h0044 || ovB !== 16'h0055) begin errors++; $display("FAIL diff_addr got wbA=%b wbB=%b vA=%h vB=%h want 1/1/0044/0055", wbA, wbB, ovA, ovB); end
    tick();
  endtask

  task automatic test_flush();
    sta = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, 1'b1, 5'(20 + i), 16'hC000 + 16'(i), 2'd0);
      tick();
    end
    checks++; if (cA !== 3'd3) begin errors++; $display("FAIL flush_fill got %0d want 3", cA); end
    flush = 1'b1; sta = 1'b0;
    drive_a(1'b1, 1'b1, 5'd30, 16'hDEAD, 2'd0);
    #1;
    checks++; if (ra !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", ra); end
    tick();
    flush = 1'b0;
    drive_a(1'b0, 1'b0, 5'd0, 16'h0000, 2'd0);
    checks++; if (cA !== 3'd0 || wbA !== 1'b0) begin errors++; $display("FAIL flush_empty got cnt=%0d wb=%b want 0/0", cA, wbA); end
    tick();
    checks++; if (cA !== 3'd0 || wbA !== 1'b0) begin errors++; $display("FAIL flush_dropped got cnt=%0d wb=%b want 0/0", cA, wbA); end
  endtask

  task automatic test_nowb_and_reset();
    drive_a(1'b1, 1'b0, 5'd9, 16'h9999, 2'd0);
    tick();
    drive_a(1'b0, 1'b0, 5'd0, 16'h0000, 2'd0);
    checks++; if (cA !== 3'd0) begin errors++; $display("FAIL nowb_count got %0d want 0", cA); end
    tick();
    checks++; if (wbA !== 1'b0) begin errors++; $display("FAIL nowb_pulse got %b want 0", wbA); end
    sta = 1'b1;
    drive_a(1'b1, 1'b1, 5'd20, 16'h5555, 2'd3);
    tick();
    drive_a(1'b1, 1'b1, 5'd21, 16'h6666, 2'd3);
    tick();
    drive_a(1'b0, 1'b0, 5'd0, 16'h0000, 2'd0);
    sta = 1'b0;
    tick();
    checks++; if (wbA !== 1'b1 || oaA !== 5'd20 || cA !== 3'd1) begin errors++; $display("FAIL pre_reset got wb=%b a=%0d cnt=%0d want 1/20/1", wbA, oaA, cA); end
    rst_n = 1'b0;
    #1;
    checks++; if (wbA !== 1'b0 || oaA !== 5'd0 || ovA !== 16'h0000 || osA !== 2'd0 || cA !== 3'd0) begin errors++; $display("FAIL mid_reset got wb=%b a=%0d v=%h s=%0d cnt=%0d want all 0", wbA, oaA, ovA, osA, cA); end
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (ra !== 1'b0) begin errors++; $display("FAIL rerelease_ready got %b want 0", ra); end
    tick();
    checks++; if (ra !== 1'b1 || cA !== 3'd0 || wbA !== 1'b0) begin errors++; $display("FAIL post_reset got rdy=%b cnt=%0d wb=%b want 1/0/0", ra, cA, wbA); end
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    drive_a(1'b1, 1'b1, 5'd3, 16'h1234, 2'd0);
    #1;
    checks++; if (wbA !== 1'b1 || ovA !== 16'h1234 || oaA !== 5'd3) begin errors++; $display("FAIL bypass got wb=%b a=%0d v=%h want 1/3/1234", wbA, oaA, ovA); end
    tick();
    drive_a(1'b0, 1'b0, 5'd0, 16'h0000, 2'd0);
    checks++; if (cA !== 3'd0) begin errors++; $display("FAIL bypass_count got %0d want 0", cA); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
`ifdef WB_BYPASS_EN
    test_bypass();
`else
    test_single();
    test_push_pop();
`endif
    test_stall_fill();
    test_same_addr();
    test_flush();
    test_nowb_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
